// File: rtl/wisard_inbuf_fifo.sv
// First-word-fall-through input buffer for the WiSARD discriminator datapath.
// Carries N_CHANNELS RAM-node addresses plus sop per word; sticky overflow on dropped pushes.
module wisard_inbuf_fifo #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int N_CHANNELS    = 4,
  parameter int DEPTH         = 4,
  parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                sop,
  input  logic                                sink_valid,
  input  logic [N_CHANNELS*ADDRESS_WIDTH-1:0] addr,
  output logic                                sink_ready,
  output logic                                sop_buf,
  output logic                                src_valid,
  output logic [N_CHANNELS*ADDRESS_WIDTH-1:0] addr_buf,
  input  logic                                src_ready,
  input  logic                                flush,
  input  logic                                ovf_clr,
  output logic                                overflow,
  output logic [CNT_WIDTH-1:0]                count
);

  localparam int WORD_W = N_CHANNELS * ADDRESS_WIDTH;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [WORD_W-1:0] addr_mem [DEPTH];
  logic [DEPTH-1:0]  sop_mem;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  assign full       = (count == FULL_CNT);
  assign src_valid  = (count != '0);
  assign sink_ready = (count < FULL_CNT);
  assign pop        = src_valid & src_ready;
  // Full with a simultaneous pop frees the slot being written, so the push is legal.
  assign push       = sink_valid & (~full | pop);
  assign drop       = sink_valid & full & ~pop & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
      end
      sop_mem <= '0;
    end else if (push && !flush) begin
      addr_mem[wr_ptr] <= addr;
      sop_mem[wr_ptr]  <= sop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // A new drop outranks a clear in the same cycle so no lost word goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign sop_buf  = src_valid & sop_mem[rd_ptr];
  assign addr_buf = src_valid ? addr_mem[rd_ptr] : '0;

endmodule
